estado_mascota: RTL and testbench
=================================

# estado_mascota

Pet-state controller that sits directly downstream of the four need-level trackers (animo, energia, descanso, medicina). It samples their 2-bit levels on a periodic tick and runs the tamagotchi behaviour FSM: FELIZ, NEUTRAL, HAMBRIENTO, CANSADO, TRISTE, ENFERMO, MUERTO. It drives the state code used by the display stage, an alarm LED and a state-change strobe. Test mode shortens the tick period so the FSM can be exercised quickly on the board.

## Interface
Parameters:
- TICK_CICLOS, 50_000_000: clock cycles per tick in normal mode (1 s at 50 MHz).
- TEST_DIV, 10: tick-rate multiplier in test mode. Test tick period = TICK_CICLOS/TEST_DIV, integer division, minimum 1.
- T_ENFERMO, 10: consecutive ticks with any level at 0 before entering ENFERMO.
- T_MUERTE, 20: ticks in ENFERMO without a cure before entering MUERTO.

Ports:
- clk  in  1  system clock; the block has this single clock.
- reset  in  1  asynchronous, active-low reset.
- test  in  1  test-mode level, already debounced.
- nivel_animo  in  2  need level; 3 = full, 0 = empty.
- nivel_energia  in  2  same encoding.
- nivel_descanso  in  2  same encoding.
- nivel_medicina  in  2  same encoding.
- estado  out  3  state code: 0 FELIZ, 1 NEUTRAL, 2 HAMBRIENTO, 3 CANSADO, 4 TRISTE, 5 ENFERMO, 6 MUERTO. Code 7 is never driven.
- alarma  out  1  registered alarm.
- cambio_estado  out  1  one-cycle strobe on every change of estado.
- tick  out  1  one-cycle tick strobe.

## Operation
- Reset values (reset=0): estado=1 (NEUTRAL), alarma=0, cambio_estado=0, tick=0. The prescaler, crit_cnt, sick_cnt and the level sample registers all clear to 0.
- Level sampling: all four levels are registered every cycle. All decisions use these registered copies.
- Prescaler: counts 0..L-1, where L = TICK_CICLOS in normal mode and TICK_CICLOS/TEST_DIV in test mode. On the terminal count it asserts tick for one cycle and wraps to 0.
  - If test rises while the count is already ≥ L-1, tick fires on the next cycle and the count clears.
- FSM updates only on the edge that ends a cycle in which tick=1. Between ticks all state is held.
- Normal states (FELIZ, NEUTRAL, HAMBRIENTO, CANSADO, TRISTE):
  - crit_cnt: if any level = 0, crit_cnt increments, saturating at T_ENFERMO. Otherwise crit_cnt clears.
  - When the incremented crit_cnt equals T_ENFERMO, the next state is ENFERMO, sick_cnt clears, and crit_cnt clears.
  - Otherwise the next state is the first match in this priority order:
    - energia ≤ 1 → HAMBRIENTO
    - descanso ≤ 1 → CANSADO
    - animo ≤ 1 → TRISTE
    - all four levels ≥ 2 and sum ≥ 10 → FELIZ. The sum is 4 bits wide, maximum 12, no overflow.
    - otherwise → NEUTRAL
- ENFERMO:
  - medicina = 3 → NEUTRAL; crit_cnt and sick_cnt clear.
  - Otherwise sick_cnt increments. When it reaches T_MUERTE, the next state is MUERTO.
- MUERTO: terminal. Only reset leaves it; tick and the levels are ignored.
- alarma = (next estado is ENFERMO or MUERTO) or (next crit_cnt ≠ 0). It is registered and updates on the same edge as estado.
- cambio_estado = 1 for exactly one cycle, the first cycle in which estado shows a value different from the previous cycle. It is never asserted when the FSM re-enters the same state.
- Asynchronous reset mid-operation: all outputs return to their reset values immediately. The first tick after release comes L cycles after reset deasserts.

## Timing
- Level-to-sample latency: 1 cycle. A level change must be present at least 1 cycle before the tick cycle to be used by that tick.
- Tick high in cycle k → estado, alarma and cambio_estado show new values in cycle k+1. cambio_estado is low again in cycle k+2.
- The first tick after reset release is in cycle L, counting the release cycle as 0.
- The test-mode switch takes effect on the cycle after test changes.

## Test plan
Parameters for all scenarios: TICK_CICLOS=10, TEST_DIV=5, T_ENFERMO=3, T_MUERTE=4.
- Reset/prescaler: hold reset=0, then release with all levels=2 → estado=1, alarma=0, tick pulses at cycles 10, 20, 30; cambio_estado stays 0 because NEUTRAL is re-entered.
- Happy path: all levels=3 → after the first tick, estado=0 with a single cambio_estado pulse; no further pulses on later ticks.
- Priority: energia=1, descanso=1, others=3 → estado=2. Then energia=3 → estado=3 after the next tick. Then descanso=3, animo=1 → estado=4.
- Sickness and cure:
  - animo=0, others=3 → alarma=1 after tick 1; estado=5 after tick 3.
  - Alternative: return animo=2 before tick 3 → crit_cnt clears, alarma=0, no ENFERMO.
  - Cure: from estado=5, medicina=3 → estado=1 and alarma=0 after the next tick.
- Death: from estado=5 with medicina=2 for 4 ticks → estado=6, alarma=1. Then all levels=3 for 5 ticks → estado stays 6. Then pulse reset=0 mid-tick-period → estado=1 immediately and the next tick comes 10 cycles after release.
- Test mode:
  - test=1 → tick period becomes 2 cycles.
  - Raise test while the prescaler count is 7 → tick on the next cycle, then every 2 cycles.
  - Drop test → period returns to 10.

Source files
------------

// File: rtl/estado_mascota_if.sv
// Pet-state bus: debounced test level and need levels in, state code, alarm and strobes out.
interface estado_mascota_if;
  logic       test;
  logic [1:0] nivel_animo;
  logic [1:0] nivel_energia;
  logic [1:0] nivel_descanso;
  logic [1:0] nivel_medicina;
  logic [2:0] estado;
  logic       alarma;
  logic       cambio_estado;
  logic       tick;

  modport master (
    output test, nivel_animo, nivel_energia, nivel_descanso, nivel_medicina,
    input  estado, alarma, cambio_estado, tick
  );

  modport slave (
    input  test, nivel_animo, nivel_energia, nivel_descanso, nivel_medicina,
    output estado, alarma, cambio_estado, tick
  );
endinterface

// File: rtl/estado_mascota.sv
// Tamagotchi behaviour controller: samples the four need levels and steps the pet FSM
// once per prescaler tick, driving the state code, a registered alarm and a change strobe.
module estado_mascota #(
  parameter int TICK_CICLOS = 50_000_000,
  parameter int TEST_DIV    = 10,
  parameter int T_ENFERMO   = 10,
  parameter int T_MUERTE    = 20
) (
  input  logic           clk,
  input  logic           reset,
  estado_mascota_if.slave bus
);

  localparam int L_NORM = (TICK_CICLOS > 1) ? TICK_CICLOS : 1;
  localparam int L_TEST = ((L_NORM / TEST_DIV) > 1) ? (L_NORM / TEST_DIV) : 1;
  localparam int CW     = (L_NORM > 1) ? $clog2(L_NORM) : 1;
  localparam int CCW    = (T_ENFERMO > 1) ? $clog2(T_ENFERMO + 1) : 1;
  localparam int SCW    = (T_MUERTE > 1) ? $clog2(T_MUERTE + 1) : 1;

  localparam logic [CW-1:0]  LIM_NORM = CW'(L_NORM - 1);
  localparam logic [CW-1:0]  LIM_TEST = CW'(L_TEST - 1);
  localparam logic [CCW-1:0] CRIT_MAX = CCW'(T_ENFERMO);
  localparam logic [SCW-1:0] SICK_MAX = SCW'(T_MUERTE);

  typedef enum logic [2:0] {
    FELIZ      = 3'd0,
    NEUTRAL    = 3'd1,
    HAMBRIENTO = 3'd2,
    CANSADO    = 3'd3,
    TRISTE     = 3'd4,
    ENFERMO    = 3'd5,
    MUERTO     = 3'd6
  } estado_t;

  logic [1:0]     animo, energia, descanso, medicina;
  logic [CW-1:0]  count;
  logic [CW-1:0]  lim;
  logic           tick_q;
  estado_t        state_q, state_d;
  logic [CCW-1:0] crit_q, crit_d, crit_inc;
  logic [SCW-1:0] sick_q, sick_d, sick_inc;
  logic           alarma_q, alarma_d;
  logic           cambio_q, cambio_d;
  logic           any_zero;
  logic           todos_altos;
  logic [3:0]     suma;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      animo    <= '0;
      energia  <= '0;
      descanso <= '0;
      medicina <= '0;
    end else begin
      animo    <= bus.nivel_animo;
      energia  <= bus.nivel_energia;
      descanso <= bus.nivel_descanso;
      medicina <= bus.nivel_medicina;
    end
  end

  // The raw test level picks the limit so a mode switch shows up on the very next edge;
  // a count already past the short limit fires immediately instead of wrapping the long way.
  assign lim = bus.test ? LIM_TEST : LIM_NORM;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count  <= '0;
      tick_q <= 1'b0;
    end else if (count >= lim) begin
      count  <= '0;
      tick_q <= 1'b1;
    end else begin
      count  <= count + 1'b1;
      tick_q <= 1'b0;
    end
  end

  assign any_zero    = (animo == 2'd0) | (energia == 2'd0) | (descanso == 2'd0) | (medicina == 2'd0);
  assign todos_altos = animo[1] & energia[1] & descanso[1] & medicina[1];
  assign suma        = {2'b00, animo} + {2'b00, energia} + {2'b00, descanso} + {2'b00, medicina};
  assign crit_inc    = (crit_q >= CRIT_MAX) ? CRIT_MAX : crit_q + 1'b1;
  assign sick_inc    = (sick_q >= SICK_MAX) ? SICK_MAX : sick_q + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= NEUTRAL;
      crit_q   <= '0;
      sick_q   <= '0;
      alarma_q <= 1'b0;
      cambio_q <= 1'b0;
    end else begin
      cambio_q <= cambio_d;
      if (tick_q) begin
        state_q  <= state_d;
        crit_q   <= crit_d;
        sick_q   <= sick_d;
        alarma_q <= alarma_d;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    crit_d  = crit_q;
    sick_d  = sick_q;
    case (state_q)
      ENFERMO: begin
        if (medicina == 2'd3) begin
          state_d = NEUTRAL;
          crit_d  = '0;
          sick_d  = '0;
        end else begin
          sick_d = sick_inc;
          if (sick_inc == SICK_MAX) state_d = MUERTO;
        end
      end
      MUERTO: begin
        state_d = MUERTO;
      end
      default: begin
        crit_d = any_zero ? crit_inc : '0;
        if (any_zero && (crit_inc == CRIT_MAX)) begin
          state_d = ENFERMO;
          sick_d  = '0;
          crit_d  = '0;
        end else if (!energia[1]) begin
          state_d = HAMBRIENTO;
        end else if (!descanso[1]) begin
          state_d = CANSADO;
        end else if (!animo[1]) begin
          state_d = TRISTE;
        end else if (todos_altos && (suma >= 4'd10)) begin
          state_d = FELIZ;
        end else begin
          state_d = NEUTRAL;
        end
      end
    endcase
    alarma_d = (state_d == ENFERMO) || (state_d == MUERTO) || (crit_d != '0);
    cambio_d = tick_q && (state_d != state_q);
  end

  assign bus.estado        = state_q;
  assign bus.alarma        = alarma_q;
  assign bus.cambio_estado = cambio_q;
  assign bus.tick          = tick_q;

endmodule

// File: tb/tb_estado_mascota.sv
// Directed scoreboard bench for estado_mascota: expectations are queued as levels are driven
// and popped once the tick that consumes them has updated the outputs.
module tb_estado_mascota;
  localparam int TICK = 10;
  localparam int DIV  = 5;
  localparam int TENF = 3;
  localparam int TMUE = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  estado_mascota_if bus();

  estado_mascota #(
    .TICK_CICLOS(TICK),
    .TEST_DIV   (DIV),
    .T_ENFERMO  (TENF),
    .T_MUERTE   (TMUE)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [2:0] estado;
    logic       alarma;
    logic       cambio;
    int         gap;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int pos_count = 0;
  int last_tick_pos = 0;

  always @(posedge clk) pos_count <= pos_count + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Returns at the falling edge of the next tick cycle, with the gap since the previous tick.
  task automatic waitTick(output int gap);
    int waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (bus.tick !== 1'b1 && waited < 40);
    if (bus.tick !== 1'b1) begin
      checkOutput("tick_timeout", {31'd0, bus.tick}, 32'd1);
      gap = -1;
    end else begin
      gap = pos_count - last_tick_pos;
      last_tick_pos = pos_count;
    end
  endtask

  task automatic applyStimulus(input logic [1:0] a, input logic [1:0] e, input logic [1:0] d,
                               input logic [1:0] m, input logic [2:0] est, input logic alm,
                               input logic cmb, input int gap, input string tag);
    exp_t x;
    int g;
    bus.nivel_animo    = a;
    bus.nivel_energia  = e;
    bus.nivel_descanso = d;
    bus.nivel_medicina = m;
    x.estado = est;
    x.alarma = alm;
    x.cambio = cmb;
    x.gap    = gap;
    x.tag    = tag;
    sb.push_back(x);
    waitTick(g);
    @(negedge clk);
    x = sb.pop_front();
    checkOutput({x.tag, "_gap"},    g,                 x.gap);
    checkOutput({x.tag, "_estado"}, bus.estado,        x.estado);
    checkOutput({x.tag, "_alarma"}, bus.alarma,        x.alarma);
    checkOutput({x.tag, "_cambio"}, bus.cambio_estado, x.cambio);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset              = 1'b0;
    bus.test           = 1'b0;
    bus.nivel_animo    = 2'd2;
    bus.nivel_energia  = 2'd2;
    bus.nivel_descanso = 2'd2;
    bus.nivel_medicina = 2'd2;
    repeat (3) @(negedge clk);
    checkOutput("rst_estado", bus.estado,        3'd1);
    checkOutput("rst_alarma", bus.alarma,        1'b0);
    checkOutput("rst_cambio", bus.cambio_estado, 1'b0);
    checkOutput("rst_tick",   bus.tick,          1'b0);
    reset = 1'b1;
    last_tick_pos = pos_count;

    $display("[TB] prescaler and neutral re-entry");
    for (int i = 0; i < 3; i++) applyStimulus(2, 2, 2, 2, 3'd1, 0, 0, 10, "neutral");

    $display("[TB] happy path");
    applyStimulus(3, 3, 3, 3, 3'd0, 0, 1, 10, "feliz");
    @(negedge clk);
    checkOutput("cambio_low", bus.cambio_estado, 1'b0);
    applyStimulus(3, 3, 3, 3, 3'd0, 0, 0, 10, "feliz_hold");

    $display("[TB] priority");
    applyStimulus(3, 1, 1, 3, 3'd2, 0, 1, 10, "hambriento");
    applyStimulus(3, 3, 1, 3, 3'd3, 0, 1, 10, "cansado");
    applyStimulus(1, 3, 3, 3, 3'd4, 0, 1, 10, "triste");

    $display("[TB] critical level recovered before sickness");
    applyStimulus(0, 3, 3, 3, 3'd4, 1, 0, 10, "crit1");
    applyStimulus(0, 3, 3, 3, 3'd4, 1, 0, 10, "crit2");
    applyStimulus(2, 3, 3, 3, 3'd0, 0, 1, 10, "recover");

    $display("[TB] sickness and cure");
    applyStimulus(0, 3, 3, 3, 3'd4, 1, 1, 10, "sick1");
    applyStimulus(0, 3, 3, 3, 3'd4, 1, 0, 10, "sick2");
    applyStimulus(0, 3, 3, 3, 3'd5, 1, 1, 10, "enfermo");
    applyStimulus(0, 3, 3, 3, 3'd1, 0, 1, 10, "cure");

    $display("[TB] death");
    applyStimulus(0, 3, 3, 2, 3'd4, 1, 1, 10, "dsick1");
    applyStimulus(0, 3, 3, 2, 3'd4, 1, 0, 10, "dsick2");
    applyStimulus(0, 3, 3, 2, 3'd5, 1, 1, 10, "denfermo");
    for (int i = 0; i < 3; i++) applyStimulus(0, 3, 3, 2, 3'd5, 1, 0, 10, "untreated");
    applyStimulus(0, 3, 3, 2, 3'd6, 1, 1, 10, "muerto");
    for (int i = 0; i < 5; i++) applyStimulus(3, 3, 3, 3, 3'd6, 1, 0, 10, "muerto_hold");

    $display("[TB] reset mid period");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("midrst_estado", bus.estado,        3'd1);
    checkOutput("midrst_alarma", bus.alarma,        1'b0);
    checkOutput("midrst_cambio", bus.cambio_estado, 1'b0);
    checkOutput("midrst_tick",   bus.tick,          1'b0);
    @(negedge clk);
    reset = 1'b1;
    last_tick_pos = pos_count;
    applyStimulus(3, 3, 3, 3, 3'd0, 0, 1, 10, "post_reset");

    $display("[TB] test mode");
    bus.test = 1'b1;
    applyStimulus(3, 3, 3, 3, 3'd0, 0, 0, 2, "fast1");
    applyStimulus(3, 3, 3, 3, 3'd0, 0, 0, 2, "fast2");
    bus.test = 1'b0;
    applyStimulus(3, 3, 3, 3, 3'd0, 0, 0, 10, "slow_again");
    repeat (6) @(negedge clk);
    bus.test = 1'b1;
    applyStimulus(3, 3, 3, 3, 3'd0, 0, 0, 8, "late_switch");
    applyStimulus(3, 3, 3, 3, 3'd0, 0, 0, 2, "fast3");
    bus.test = 1'b0;
    applyStimulus(3, 3, 3, 3, 3'd0, 0, 0, 10, "slow_final");

    checkOutput("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
